// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the architectural PC, issues in-order
// fetches to instruction memory under a credit limit, tags each fetch with
// its PC, buffers returned words and presents {pc, instr, pc+4} to decode.
// Redirects from execute retarget the PC, flush the buffer and mark every
// still-in-flight fetch as stale so its response is dropped on arrival.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_plus4_o
);

  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  typedef enum logic {BOOT, RUN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;

  logic [31:0]   tag_mem [FIFO_DEPTH];
  logic [PW-1:0] tag_wr_q, tag_rd_q;

  entry_t        buf_mem [FIFO_DEPTH];
  logic [PW-1:0] buf_wr_q, buf_rd_q;

  logic [CW-1:0] count_q, outstanding_q, drop_cnt_q;

  logic          flush, req_fire, rsp_fire, rsp_drop, push, pop;
  entry_t        head;

  // The redirect target is word-aligned; its two low bits are dropped on purpose.
  logic          unused_rpc_bits;
  assign unused_rpc_bits = ^redirect_pc_i[1:0];

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // State register: BOOT for one cycle after reset, then RUN forever.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Next state and the credit-limited request strobe.
  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d          = state_q;
    imem_req_valid_o = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN:  imem_req_valid_o = !redirect_i &&
                               (({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_W);
    endcase
  end

  assign flush    = redirect_i && (state_q == RUN);
  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  assign rsp_fire = imem_rsp_valid_i && (outstanding_q != '0);
  assign rsp_drop = rsp_fire && (drop_cnt_q != '0);
  assign push     = rsp_fire && !rsp_drop && !flush;
  assign pop      = if_valid_o && if_ready_i && !flush;

  assign imem_req_addr_o = pc_q;

  // Architectural PC: redirect wins, otherwise advance on each accepted fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pc_q <= RESET_PC;
    else if (redirect_i) pc_q <= {redirect_pc_i[31:2], 2'b00};
    else if (req_fire)   pc_q <= pc_q + 32'd4;
  end

  // Storage arrays for fetch tags and buffered instructions.
  // NOTE: the arrays carry no reset; pointers and counts gate every read of them.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_q] <= pc_q;
    if (push)     buf_mem[buf_wr_q] <= '{pc: tag_mem[tag_rd_q], instr: imem_rsp_data_i};
  end

  // Tag queue pointers: written on accept, consumed by every response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      if (req_fire) tag_wr_q <= ptr_inc(tag_wr_q);
      if (rsp_fire) tag_rd_q <= ptr_inc(tag_rd_q);
    end
  end

  // In-flight fetch counter; a same-cycle accept and response cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
    end else begin
      unique case ({req_fire, rsp_fire})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Stale-response counter: a redirect condemns everything still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           drop_cnt_q <= '0;
    else if (flush)    drop_cnt_q <= outstanding_q - CW'(rsp_fire);
    else if (rsp_drop) drop_cnt_q <= drop_cnt_q - 1'b1;
  end

  // Instruction buffer bookkeeping; a redirect empties it outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_wr_q <= '0;
      buf_rd_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      buf_wr_q <= '0;
      buf_rd_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) buf_wr_q <= ptr_inc(buf_wr_q);
      if (pop)  buf_rd_q <= ptr_inc(buf_rd_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign head          = buf_mem[buf_rd_q];
  assign if_valid_o    = (count_q != '0);
  assign if_pc_o       = if_valid_o ? head.pc    : 32'h0;
  assign if_instr_o    = if_valid_o ? head.instr : NOP;
  assign if_pc_plus4_o = if_pc_o + 32'd4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, reset corner sequences and
// a randomized run scored against a queue-based reference model. A second
// instance with RESET_PC=FFFF_FFF8 runs in lockstep to exercise PC wrap.
module tb_if_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic        H     = 1'b1;
  localparam logic        L     = 1'b0;
  localparam int          NROWS = 27;
  localparam int          NRAND = 3000;

  logic        clk, rst;
  logic        redirect, req_ready, rsp_valid, dec_ready;
  logic [31:0] redirect_pc, rsp_data;

  logic        req_valid, if_valid;
  logic [31:0] req_addr, if_pc, if_instr, if_pc4;
  logic        req_valid1, if_valid1;
  logic [31:0] req_addr1, if_pc1, if_instr1, if_pc41;

  int tests = 0;
  int fails = 0;

  logic [31:0] pend [$];

  if_fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
    .imem_req_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .if_valid_o(if_valid), .if_ready_i(dec_ready),
    .if_pc_o(if_pc), .if_instr_o(if_instr), .if_pc_plus4_o(if_pc4)
  );

  if_fetch_stage #(.RESET_PC(RPC1), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(req_valid1), .imem_req_ready_i(req_ready),
    .imem_req_addr_o(req_addr1),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .if_valid_o(if_valid1), .if_ready_i(dec_ready),
    .if_pc_o(if_pc1), .if_instr_o(if_instr1), .if_pc_plus4_o(if_pc41)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Instruction memory content: a per-address word, distinct from NOP.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; the imem responder answers the oldest pending fetch.
  task automatic drive(input logic rd, input logic [31:0] rpc, input logic irdy,
                       input logic drdy, input logic rsp_en);
    redirect    = rd;
    redirect_pc = rpc;
    req_ready   = irdy;
    dec_ready   = drdy;
    rsp_valid   = rsp_en && (pend.size() > 0);
    rsp_data    = rsp_valid ? instr_of(pend[0]) : 32'hDEAD_BEEF;
    #1;
  endtask

  // Retire this cycle's imem traffic and move to just after the next edge.
  task automatic advance();
    if (rsp_valid) void'(pend.pop_front());
    if (req_valid && req_ready) pend.push_back(req_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(L, 32'h0, L, L, L);
    pend.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        irdy, drdy, rsp_en;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [NROWS];

  typedef struct { logic [31:0] addr; logic stale; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } slot_t;

  flight_t     m_inflight [$];
  slot_t       m_buf [$];
  logic        m_boot;
  logic [31:0] m_pc;

  initial begin
    // Directed table, starting on the first cycle after reset release.
    tbl[0]  = '{L, 32'h0,   H, H, H,  L, 32'h000, L, 32'h000};
    tbl[1]  = '{L, 32'h0,   H, H, H,  H, 32'h000, L, 32'h000};
    tbl[2]  = '{L, 32'h0,   H, H, H,  H, 32'h004, L, 32'h000};
    tbl[3]  = '{L, 32'h0,   H, H, H,  L, 32'h008, H, 32'h000};
    tbl[4]  = '{L, 32'h0,   H, H, H,  H, 32'h008, H, 32'h004};
    tbl[5]  = '{L, 32'h0,   H, H, H,  H, 32'h00C, L, 32'h000};
    tbl[6]  = '{L, 32'h0,   H, H, H,  L, 32'h010, H, 32'h008};
    tbl[7]  = '{L, 32'h0,   H, H, H,  H, 32'h010, H, 32'h00C};
    tbl[8]  = '{L, 32'h0,   H, L, H,  H, 32'h014, L, 32'h000};
    tbl[9]  = '{L, 32'h0,   H, L, H,  L, 32'h018, H, 32'h010};
    tbl[10] = '{L, 32'h0,   H, L, H,  L, 32'h018, H, 32'h010};
    tbl[11] = '{L, 32'h0,   H, L, H,  L, 32'h018, H, 32'h010};
    tbl[12] = '{L, 32'h0,   H, H, H,  L, 32'h018, H, 32'h010};
    tbl[13] = '{L, 32'h0,   H, H, H,  H, 32'h018, H, 32'h014};
    tbl[14] = '{L, 32'h0,   H, H, L,  H, 32'h01C, L, 32'h000};
    tbl[15] = '{H, 32'h103, H, H, L,  L, 32'h020, L, 32'h000};
    tbl[16] = '{L, 32'h0,   H, H, H,  L, 32'h100, L, 32'h000};
    tbl[17] = '{L, 32'h0,   H, H, H,  H, 32'h100, L, 32'h000};
    tbl[18] = '{L, 32'h0,   H, H, H,  H, 32'h104, L, 32'h000};
    tbl[19] = '{L, 32'h0,   H, H, H,  L, 32'h108, H, 32'h100};
    tbl[20] = '{H, 32'h200, H, H, H,  L, 32'h108, H, 32'h104};
    tbl[21] = '{L, 32'h0,   H, H, H,  H, 32'h200, L, 32'h000};
    tbl[22] = '{L, 32'h0,   H, H, H,  H, 32'h204, L, 32'h000};
    tbl[23] = '{H, 32'h301, H, H, H,  L, 32'h208, H, 32'h200};
    tbl[24] = '{L, 32'h0,   H, H, H,  H, 32'h300, L, 32'h000};
    tbl[25] = '{L, 32'h0,   H, H, H,  H, 32'h304, L, 32'h000};
    tbl[26] = '{L, 32'h0,   H, H, H,  L, 32'h308, H, 32'h300};

    // Reset held three cycles: everything idle, NOP on the decode port.
    rst = 1'b1;
    drive(L, 32'h0, H, H, L);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst%0d if_valid", c), {31'b0, if_valid}, 32'h0);
      check($sformatf("rst%0d req_valid", c), {31'b0, req_valid}, 32'h0);
      check($sformatf("rst%0d addr", c), req_addr, 32'h0);
      check($sformatf("rst%0d instr", c), if_instr, NOP);
      check($sformatf("rst%0d pc", c), if_pc, 32'h0);
      check($sformatf("rst%0d pc4", c), if_pc4, 32'h4);
      check($sformatf("rst%0d wrap_addr", c), req_addr1, RPC1);
    end
    rst = 1'b0;

    for (int r = 0; r < NROWS; r++) begin
      drive(tbl[r].redir, tbl[r].rpc, tbl[r].irdy, tbl[r].drdy, tbl[r].rsp_en);
      check($sformatf("r%0d req_valid", r), {31'b0, req_valid}, {31'b0, tbl[r].req});
      check($sformatf("r%0d addr", r), req_addr, tbl[r].addr);
      check($sformatf("r%0d if_valid", r), {31'b0, if_valid}, {31'b0, tbl[r].vld});
      if (tbl[r].vld) begin
        check($sformatf("r%0d pc", r), if_pc, tbl[r].pc);
        check($sformatf("r%0d instr", r), if_instr, instr_of(tbl[r].pc));
        check($sformatf("r%0d pc4", r), if_pc4, tbl[r].pc + 32'd4);
      end
      if (r < 15) begin
        check($sformatf("r%0d wrap_req", r), {31'b0, req_valid1}, {31'b0, tbl[r].req});
        check($sformatf("r%0d wrap_addr", r), req_addr1, tbl[r].addr + RPC1);
        if (tbl[r].vld) begin
          check($sformatf("r%0d wrap_pc", r), if_pc1, tbl[r].pc + RPC1);
          check($sformatf("r%0d wrap_pc4", r), if_pc41, tbl[r].pc + RPC1 + 32'd4);
        end
      end
      advance();
    end

    // Reset mid-stream with one buffered and one outstanding fetch.
    drive(L, 32'h0, H, L, L);
    check("mid0 req_valid", {31'b0, req_valid}, 32'h1);
    check("mid0 addr", req_addr, 32'h308);
    check("mid0 pc", if_pc, 32'h304);
    advance();
    drive(L, 32'h0, H, L, L);
    check("mid1 req_valid", {31'b0, req_valid}, 32'h0);
    check("mid1 if_valid", {31'b0, if_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst if_valid", {31'b0, if_valid}, 32'h0);
    check("midrst req_valid", {31'b0, req_valid}, 32'h0);
    check("midrst addr", req_addr, 32'h0);
    check("midrst instr", if_instr, NOP);
    pend.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(L, 32'h0, H, H, H);
    check("post boot req_valid", {31'b0, req_valid}, 32'h0);
    check("post boot addr", req_addr, 32'h0);
    advance();
    drive(L, 32'h0, H, H, H);
    check("post run req_valid", {31'b0, req_valid}, 32'h1);
    check("post run addr", req_addr, 32'h0);
    advance();

    // Randomized run against the queue-based reference model.
    do_reset();
    m_inflight.delete();
    m_buf.delete();
    m_boot = 1'b1;
    m_pc   = 32'h0;
    for (int c = 0; c < NRAND; c++) begin
      logic        rd, irdy, drdy, en, exp_req, exp_vld, rd_eff;
      logic [31:0] rpc;
      rd   = ($urandom_range(19) == 0);
      rpc  = $urandom;
      irdy = ($urandom_range(3) != 0);
      drdy = ($urandom_range(2) != 0);
      en   = ($urandom_range(2) != 0);
      drive(rd, rpc, irdy, drdy, en);

      exp_req = !m_boot && !rd && ((m_inflight.size() + m_buf.size()) < DEPTH);
      exp_vld = (m_buf.size() > 0);
      check($sformatf("rnd%0d req_valid", c), {31'b0, req_valid}, {31'b0, exp_req});
      check($sformatf("rnd%0d addr", c), req_addr, m_pc);
      check($sformatf("rnd%0d if_valid", c), {31'b0, if_valid}, {31'b0, exp_vld});
      if (exp_vld) begin
        check($sformatf("rnd%0d pc", c), if_pc, m_buf[0].pc);
        check($sformatf("rnd%0d instr", c), if_instr, m_buf[0].instr);
        check($sformatf("rnd%0d pc4", c), if_pc4, m_buf[0].pc + 32'd4);
      end

      rd_eff = rd && !m_boot;
      if (exp_vld && drdy && !rd_eff) void'(m_buf.pop_front());
      if (rsp_valid && m_inflight.size() > 0) begin
        flight_t f;
        f = m_inflight.pop_front();
        if (!f.stale && !rd_eff) m_buf.push_back('{pc: f.addr, instr: rsp_data});
      end
      if (rd) begin
        m_pc = {rpc[31:2], 2'b00};
        if (rd_eff) begin
          m_buf.delete();
          foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
        end
      end else if (exp_req && irdy) begin
        m_inflight.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
